// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared types and helpers for the sequential switch/button ALU.
//   op_t    : operation codes. The value of each code is the index of its
//             button in the top level's button vector, so the lowest set
//             index is the one with the highest priority.
//   state_t : top-level FSM states.
//   lo_f / popcount_f : width-parametrised bit-counting helpers. The caller
//             zero-extends its operand to MAX_W and passes the real width.
package seq_alu_pkg;

    localparam int MAX_W = 64;  // widest SW vector the helpers support

    typedef enum logic [2:0] {
        OP_MULT = 3'd0,
        OP_LO   = 3'd1,
        OP_NO   = 3'd2,
        OP_ADD  = 3'd3,
        OP_SUB  = 3'd4
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2
    } state_t;

    // Index of the highest set bit plus one; 0 when no bit is set.
    function automatic logic [31:0] lo_f(input logic [MAX_W-1:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w && v[i]) r = 32'(i + 1);
        end
        return r;
    endfunction

    function automatic logic [31:0] popcount_f(input logic [MAX_W-1:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) r = r + 32'(v[i]);
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_mult.sv
// seq_mult: N-cycle signed multiplier (sign-magnitude shift-and-add).
//   clk, CPU_RESETN : clock, async active-low reset
//   start           : one-cycle pulse; a and b are latched on this edge
//   a, b            : two's complement operands, N bits each
//   product         : exact signed 2N-bit product, valid while done = 1
//   done            : high during the last of the N iterations
// product and done are combinational from the final iteration so that the
// caller can register them in the same edge that finishes the iteration.
module seq_mult #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           CPU_RESETN,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] product,
    output logic           done
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic           run_q, run_d;
    logic           neg_q, neg_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] mcand_q, mcand_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [2*N-1:0] acc_nx;
    logic [N-1:0]   mag_a, mag_b;
    logic           last;

    always_comb begin
        // -2^(N-1) has magnitude 2^(N-1), which still fits unsigned in N bits.
        mag_a    = a[N-1] ? -a : a;
        mag_b    = b[N-1] ? -b : b;
        acc_nx   = acc_q + (mplier_q[0] ? mcand_q : '0);
        last     = run_q && (cnt_q == CW'(N - 1));
        product  = neg_q ? -acc_nx : acc_nx;
        done     = last;

        run_d    = run_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;

        if (start) begin
            run_d    = 1'b1;
            neg_d    = a[N-1] ^ b[N-1];
            cnt_d    = '0;
            mcand_d  = {{N{1'b0}}, mag_a};
            acc_d    = '0;
            mplier_d = mag_b;
        end else if (run_q) begin
            acc_d    = acc_nx;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (last) run_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            run_q    <= 1'b0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
        end else begin
            run_q    <= run_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered switch/button ALU.
//   clk, CPU_RESETN : clock, async active-low reset
//   SW              : A = SW[BITS-1:N], B = SW[N-1:0], two's complement
//   BTNC/U/D/L/R    : async buttons -> MULT / LEADING_ONES / NUM_ONES / ADD / SUB
//   LED             : last completed result (held until the next done)
//   busy            : operation in progress
//   done            : one-cycle pulse when LED takes a new value
// BITS must be even, >= 4 and <= MAX_W; SYNC_STAGES >= 2.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int BITS        = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            CPU_RESETN,
    input  logic [BITS-1:0] SW,
    input  logic            BTNC,
    input  logic            BTNU,
    input  logic            BTND,
    input  logic            BTNL,
    input  logic            BTNR,
    output logic [BITS-1:0] LED,
    output logic            busy,
    output logic            done
);
    localparam int N = BITS / 2;

    // Bit i of btn is the button for op_t value i.
    logic [4:0] btn;
    logic [4:0] btn_s;
    assign btn = {BTNR, BTNL, BTND, BTNU, BTNC};

    for (genvar g = 0; g < 5; g++) begin : g_sync
        logic [SYNC_STAGES-1:0] chain_q, chain_d;
        always_comb chain_d = {chain_q[SYNC_STAGES-2:0], btn[g]};
        always_ff @(posedge clk or negedge CPU_RESETN) begin
            if (!CPU_RESETN) chain_q <= '0;
            else             chain_q <= chain_d;
        end
        assign btn_s[g] = chain_q[SYNC_STAGES-1];
    end

    // The cleared synchronisers refill after reset release, which would look
    // like a rising edge for any button held across reset. warm_q masks edge
    // detection until both the chains and prev_q carry real button levels.
    logic [SYNC_STAGES:0] warm_q, warm_d;
    logic [4:0]           prev_q, prev_d;
    logic [4:0]           start_q, start_d;

    always_comb begin
        warm_d  = {warm_q[SYNC_STAGES-1:0], 1'b1};
        prev_d  = btn_s;
        start_d = btn_s & ~prev_q & {5{warm_q[SYNC_STAGES]}};
    end

    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            warm_q  <= '0;
            prev_q  <= '0;
            start_q <= '0;
        end else begin
            warm_q  <= warm_d;
            prev_q  <= prev_d;
            start_q <= start_d;
        end
    end

    // Fixed priority C > U > D > L > R, i.e. lowest index wins.
    op_t sel_op;
    always_comb begin
        sel_op = OP_MULT;
        for (int i = 4; i >= 0; i--) begin
            if (start_q[i]) sel_op = op_t'(3'(i));
        end
    end

    state_t          state_q, state_d;
    op_t             op_q, op_d;
    logic [BITS-1:0] sw_q, sw_d;
    logic [BITS-1:0] led_q, led_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            mult_start;
    logic [BITS-1:0] mult_product;
    logic            mult_done;

    seq_mult #(.N(N)) u_mult (
        .clk        (clk),
        .CPU_RESETN (CPU_RESETN),
        .start      (mult_start),
        .a          (SW[BITS-1:N]),
        .b          (SW[N-1:0]),
        .product    (mult_product),
        .done       (mult_done)
    );

    // Single-cycle operations work from the captured switches.
    logic [N-1:0]    opa, opb;
    logic [N:0]      sum, dif;
    logic [BITS-1:0] exec_res;
    always_comb begin
        opa = sw_q[BITS-1:N];
        opb = sw_q[N-1:0];
        sum = {opa[N-1], opa} + {opb[N-1], opb};
        dif = {opa[N-1], opa} - {opb[N-1], opb};
        case (op_q)
            OP_LO:   exec_res = BITS'(lo_f(MAX_W'(sw_q), BITS));
            OP_NO:   exec_res = BITS'(popcount_f(MAX_W'(sw_q), BITS));
            OP_ADD:  exec_res = {{(BITS-N-1){sum[N]}}, sum};
            OP_SUB:  exec_res = {{(BITS-N-1){dif[N]}}, dif};
            default: exec_res = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        sw_d       = sw_q;
        led_d      = led_q;
        done_d     = 1'b0;
        mult_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (|start_q) begin
                    sw_d = SW;
                    op_d = sel_op;
                    if (sel_op == OP_MULT) begin
                        state_d    = MUL;
                        mult_start = 1'b1;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                led_d   = exec_res;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            MUL: begin
                if (mult_done) begin
                    led_d   = mult_product;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q <= IDLE;
            op_q    <= OP_MULT;
            sw_q    <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sw_q    <= sw_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign LED  = led_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (BITS = 16, SYNC_STAGES = 2). A cycle-level behavioural
// model derived from the timing rules (edge -> accept SYNC_STAGES+1 cycles
// later, fixed latency per op, busy drops requests) is compared with the DUT
// every cycle; directed cases pin the model with literal results.
module tb_seq_alu;
    localparam int BITS = 16;
    localparam int S    = 2;
    localparam int N    = BITS / 2;
    localparam int HL   = S + 3;

    logic            clk = 1'b0;
    logic            CPU_RESETN;
    logic [BITS-1:0] SW;
    logic [4:0]      btn;  // {R, L, D, U, C}
    logic [BITS-1:0] LED;
    logic            busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_alu #(.BITS(BITS), .SYNC_STAGES(S)) dut (
        .clk        (clk),
        .CPU_RESETN (CPU_RESETN),
        .SW         (SW),
        .BTNC       (btn[0]),
        .BTNU       (btn[1]),
        .BTND       (btn[2]),
        .BTNL       (btn[3]),
        .BTNR       (btn[4]),
        .LED        (LED),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [4:0]      hist [HL];  // hist[j] = buttons sampled j edges ago
    logic [4:0]      cand;
    logic [BITS-1:0] exp_led, res;
    bit              exp_busy, exp_done, pending, mvalid;
    int              e, free_at, fin_at;

    initial begin
        exp_led = '0; exp_busy = 0; exp_done = 0; pending = 0; mvalid = 0;
        e = 0; free_at = 0; fin_at = 0;
    end

    function automatic logic [BITS-1:0] model_res(input int op, input logic [BITS-1:0] sw);
        int a, b, r;
        a = int'($signed(sw[BITS-1:N]));
        b = int'($signed(sw[N-1:0]));
        r = 0;
        case (op)
            0: r = a * b;
            1: for (int j = 0; j < BITS; j++) if (sw[j]) r = j + 1;
            2: r = $countones(sw);
            3: r = a + b;
            default: r = a - b;
        endcase
        return r[BITS-1:0];
    endfunction

    always @(posedge clk) begin
        mvalid = 1;
        if (!CPU_RESETN) begin
            exp_led = '0; exp_busy = 0; exp_done = 0; pending = 0;
            free_at = 0; e = 0;
            for (int j = 0; j < HL; j++) hist[j] = btn;  // levels at release are not edges
        end else begin
            int op;
            e++;
            exp_done = 0;
            if (pending && e == fin_at) begin
                exp_led = res; exp_done = 1; exp_busy = 0; pending = 0;
            end
            for (int j = HL - 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = btn;
            cand = hist[S+1] & ~hist[S+2];
            if (e >= free_at && cand != 0) begin
                op = 4;
                for (int j = 4; j >= 0; j--) if (cand[j]) op = j;
                res      = model_res(op, SW);
                fin_at   = e + ((op == 0) ? N : 1);
                free_at  = fin_at + 1;
                pending  = 1;
                exp_busy = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("led", 32'(LED), 32'(exp_led));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("done", 32'(done), 32'(exp_done));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic do_op(input string nm, input logic [15:0] sw, input logic [4:0] mask,
                         input logic [4:0] mid_btn, input bit chg,
                         input logic [15:0] exp_val, input int exp_lat, input int exp_bn);
        int lat, bc, dc;
        bit got;
        logic [15:0] got_led;
        lat = 0; bc = 0; dc = 0; got = 0; got_led = '0;
        @(negedge clk); #2;
        SW = sw; btn = mask;
        for (int i = 1; i <= 40 && !(got && i > lat + 2); i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) begin
                dc++;
                if (!got) begin got = 1; lat = i; got_led = LED; end
            end
            if (i == 3) begin #2; btn = '0; end
            if (i == 6) begin #2; btn = mid_btn; if (chg) SW = ~sw; end
            if (i == 8) begin #2; btn = '0; end
        end
        chk({nm, " completed"}, 32'(got), 32'd1);
        chk({nm, " result"}, 32'(got_led), 32'(exp_val));
        chk({nm, " latency"}, lat, exp_lat);
        chk({nm, " busy cycles"}, bc, exp_bn);
        chk({nm, " done count"}, dc, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, t;
        CPU_RESETN = 1'b1; SW = '0; btn = 5'b00010;  // BTNU held through reset
        #1 CPU_RESETN = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset led", 32'(LED), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset done", 32'(done), 32'h0);
        #2 CPU_RESETN = 1'b1;
        dc = 0;
        repeat (15) begin @(negedge clk); if (done || busy) dc++; end
        #2 btn = '0;
        repeat (10) begin @(negedge clk); if (done || busy) dc++; end
        chk("held button at release", dc, 0);

        // latency: S+3 for single-cycle ops, S+2+N for MULT (bench drive -> done)
        do_op("add",      16'h7F80, 5'b01000, 5'b00000, 0, 16'hFFFF, S + 3, 1);
        do_op("sub",      16'h807F, 5'b10000, 5'b00000, 0, 16'hFF01, S + 3, 1);
        do_op("mul min",  16'h8080, 5'b00001, 5'b00000, 0, 16'h4000, S + 2 + N, N);
        do_op("mul swchg",16'h7F80, 5'b00001, 5'b00000, 1, 16'hC080, S + 2 + N, N);
        do_op("lo 0400",  16'h0400, 5'b00010, 5'b00000, 0, 16'h000B, S + 3, 1);
        do_op("lo 0000",  16'h0000, 5'b00010, 5'b00000, 0, 16'h0000, S + 3, 1);
        do_op("no ffff",  16'hFFFF, 5'b00100, 5'b00000, 0, 16'h0010, S + 3, 1);
        do_op("mul+btnr", 16'h0703, 5'b00001, 5'b10000, 0, 16'h0015, S + 2 + N, N);
        do_op("c+l same", 16'h0503, 5'b01001, 5'b00000, 0, 16'h000F, S + 2 + N, N);

        // reset in the middle of a multiply
        @(negedge clk); #2 SW = 16'h7F7F; btn = 5'b00001;
        repeat (3) @(negedge clk);
        #2 btn = '0;
        t = 0;
        while (!busy && t < 20) begin @(negedge clk); t++; end
        chk("rstmul busy seen", 32'(busy), 32'd1);
        repeat (4) @(negedge clk);
        #2 CPU_RESETN = 1'b0;
        dc = 0;
        repeat (6) begin @(negedge clk); if (done) dc++; end
        chk("rstmul led", 32'(LED), 32'h0);
        #2 CPU_RESETN = 1'b1;
        repeat (10) begin @(negedge clk); if (done) dc++; end
        chk("rstmul no done", dc, 0);
        do_op("mul after rst", 16'h0302, 5'b00001, 5'b00000, 0, 16'h0006, S + 2 + N, N);

        // randomized presses, including overlaps and presses while busy
        for (int k = 0; k < 150; k++) begin
            @(negedge clk); #2;
            SW  = 16'($urandom);
            btn = ($urandom_range(0, 3) == 0) ? 5'b0 : 5'($urandom_range(0, 31));
            repeat ($urandom_range(1, 6)) @(negedge clk);
            #2 btn = '0;
            repeat ($urandom_range(0, 12)) @(negedge clk);
        end
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
